// File: rtl/lwe_pkg.sv
// Shared LWE decrypt definitions: default moduli/widths, message row index,
// FSM state encoding and the rounding-offset helper q/(2p).
package lwe_pkg;

  localparam int unsigned DEF_PLAINTEXT_MODULUS  = 64;
  localparam int unsigned DEF_PLAINTEXT_WIDTH    = 6;
  localparam int unsigned DEF_CIPHERTEXT_MODULUS = 1024;
  localparam int unsigned DEF_CIPHERTEXT_WIDTH   = 10;
  localparam int unsigned DEF_DIMENSION          = 10;

  // Row carrying the message-bearing word; every other row is a key term.
  localparam int unsigned MSG_ROW = 1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    ROUND = 2'd1,
    OUT   = 2'd2
  } state_e;

  function automatic int unsigned round_offset(input int unsigned q, input int unsigned p);
    return q / (2 * p);
  endfunction

endpackage

// File: rtl/modq_mac.sv
// Combinational mod-q accumulate step: adds the message word or subtracts c*s.
module modq_mac #(
  parameter int unsigned CIPHERTEXT_WIDTH = 10
) (
  input  logic [CIPHERTEXT_WIDTH-1:0] acc,
  input  logic [CIPHERTEXT_WIDTH-1:0] ciphertext,
  input  logic [CIPHERTEXT_WIDTH-1:0] secretkey,
  input  logic                        is_msg_row,
  output logic [CIPHERTEXT_WIDTH-1:0] acc_next
);

  logic [CIPHERTEXT_WIDTH-1:0] mul_lo;

  // q is a power of two, so mod q is plain truncation to the word width.
  assign mul_lo   = ciphertext * secretkey;
  assign acc_next = is_msg_row ? (acc + ciphertext) : (acc - mul_lo);

endmodule

// File: rtl/decrypt.sv
// LWE decrypt: accumulates a DIMENSION+1 word frame mod q, rounds to plaintext.
// Optional macro DECRYPT_NOISE_OUT_EN adds a registered noise output port.
module decrypt
  import lwe_pkg::*;
#(
  parameter int unsigned PLAINTEXT_MODULUS  = DEF_PLAINTEXT_MODULUS,
  parameter int unsigned PLAINTEXT_WIDTH    = DEF_PLAINTEXT_WIDTH,
  parameter int unsigned CIPHERTEXT_MODULUS = DEF_CIPHERTEXT_MODULUS,
  parameter int unsigned CIPHERTEXT_WIDTH   = DEF_CIPHERTEXT_WIDTH,
  parameter int unsigned DIMENSION          = DEF_DIMENSION
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CIPHERTEXT_WIDTH-1:0] ciphertext,
  input  logic [CIPHERTEXT_WIDTH-1:0] secretkey,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PLAINTEXT_WIDTH-1:0]  plaintext
`ifdef DECRYPT_NOISE_OUT_EN
  ,
  output logic [CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH-1:0] noise
`endif
);

  localparam int unsigned ROW_W   = (DIMENSION < 2) ? 1 : $clog2(DIMENSION + 1);
  localparam int unsigned NOISE_W = CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH;
  localparam logic [CIPHERTEXT_WIDTH-1:0] ROUND_OFS =
    CIPHERTEXT_WIDTH'(round_offset(CIPHERTEXT_MODULUS, PLAINTEXT_MODULUS));

  state_e                      state_q, state_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [CIPHERTEXT_WIDTH-1:0] acc_q, acc_d;
  logic [PLAINTEXT_WIDTH-1:0]  pt_q, pt_d;
  logic                        out_valid_q, out_valid_d;
  logic                        in_ready_q, in_ready_d;
`ifdef DECRYPT_NOISE_OUT_EN
  logic [NOISE_W-1:0]          noise_q, noise_d;
`endif

  logic                        xfer;
  logic                        last_row;
  logic                        is_msg_row;
  logic [CIPHERTEXT_WIDTH-1:0] acc_mac;
  logic [CIPHERTEXT_WIDTH-1:0] acc_rnd;

  assign xfer       = in_valid && in_ready_q;
  assign last_row   = (row_q == ROW_W'(DIMENSION));
  assign is_msg_row = (row_q == ROW_W'(MSG_ROW));
  assign acc_rnd    = acc_q + ROUND_OFS;

  modq_mac #(
    .CIPHERTEXT_WIDTH(CIPHERTEXT_WIDTH)
  ) u_mac (
    .acc        (acc_q),
    .ciphertext (ciphertext),
    .secretkey  (secretkey),
    .is_msg_row (is_msg_row),
    .acc_next   (acc_mac)
  );

  // State and datapath registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      row_q       <= '0;
      acc_q       <= '0;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef DECRYPT_NOISE_OUT_EN
      noise_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      acc_q       <= acc_d;
      pt_q        <= pt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef DECRYPT_NOISE_OUT_EN
      noise_q     <= noise_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (xfer && last_row) state_d = ROUND;
      ROUND:   state_d = OUT;
      OUT:     if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Datapath and registered handshake outputs, derived from the next state.
  always_comb begin
    row_d       = row_q;
    acc_d       = acc_q;
    pt_d        = pt_q;
    out_valid_d = (state_d == OUT);
    in_ready_d  = (state_d == ACCUM);
`ifdef DECRYPT_NOISE_OUT_EN
    noise_d     = noise_q;
`endif
    unique case (state_q)
      ACCUM: begin
        if (xfer) begin
          acc_d = acc_mac;
          row_d = last_row ? '0 : row_q + ROW_W'(1);
        end
      end
      ROUND: begin
        pt_d  = acc_rnd[CIPHERTEXT_WIDTH-1 -: PLAINTEXT_WIDTH];
`ifdef DECRYPT_NOISE_OUT_EN
        noise_d = acc_q[NOISE_W-1:0];
`endif
        // acc is already captured; clearing here readies the next frame.
        acc_d = '0;
      end
      OUT: begin
        acc_d = '0;
      end
      default: begin
        row_d = '0;
        acc_d = '0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign plaintext = pt_q;
`ifdef DECRYPT_NOISE_OUT_EN
  assign noise     = noise_q;
`endif

endmodule

// File: tb/tb_decrypt.sv
// Self-checking bench for decrypt: directed vector table, handshake/reset
// sequences and randomized frames against an arithmetic reference model.
module tb_decrypt;

  localparam int PW  = 6;
  localparam int CW  = 10;
  localparam int DIM = 10;
  localparam int P   = 64;
  localparam int Q   = 1024;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] ciphertext;
  logic [CW-1:0] secretkey;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] plaintext;
`ifdef DECRYPT_NOISE_OUT_EN
  logic [CW-PW-1:0] noise;
`endif

  int checks;
  int errors;
  int c_arr[0:DIM];
  int s_arr[0:DIM];

  typedef struct {
    int c0;
    int s0;
    int c1;
    int exp_pt;
  } vec_t;

  vec_t tbl[5];

  decrypt #(
    .PLAINTEXT_MODULUS  (P),
    .PLAINTEXT_WIDTH    (PW),
    .CIPHERTEXT_MODULUS (Q),
    .CIPHERTEXT_WIDTH   (CW),
    .DIMENSION          (DIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .secretkey  (secretkey),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext)
`ifdef DECRYPT_NOISE_OUT_EN
    ,
    .noise      (noise)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp_v);
    end
  endtask

  // Reference: plaintext = round(p/q * (b - sum a_i*s_i)) mod p, with plain integers.
  function automatic int model_pt();
    longint tot;
    tot = c_arr[1];
    for (int r = 0; r <= DIM; r++)
      if (r != 1) tot -= longint'(c_arr[r]) * s_arr[r];
    tot = ((tot % Q) + Q) % Q;
    return int'(((tot + Q / (2 * P)) % Q) / (Q / P));
  endfunction

  task automatic clear_frame();
    for (int r = 0; r <= DIM; r++) begin
      c_arr[r] = 0;
      s_arr[r] = 0;
    end
  endtask

  task automatic send_rows(input string nm, input int first, input int last);
    int n;
    for (int r = first; r <= last; r++) begin
      @(negedge clk);
      in_valid   = 1'b1;
      ciphertext = CW'(c_arr[r]);
      secretkey  = CW'(s_arr[r]);
      n = 0;
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("%s_ready_wait_row%0d", nm, r), n, 0);
      @(posedge clk);
    end
  endtask

  task automatic finish_frame(input string nm, input int exp_pt, input int hold);
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, "_ov_in_round"}, int'(out_valid), 0);
    chk({nm, "_rdy_in_round"}, int'(in_ready), 0);
    @(negedge clk);
    chk({nm, "_ov_in_out"}, int'(out_valid), 1);
    chk({nm, "_pt"}, int'(plaintext), exp_pt);
    for (int h = 0; h < hold; h++) begin
      in_valid   = 1'b1;
      ciphertext = CW'(500);
      secretkey  = CW'(3);
      @(negedge clk);
      chk($sformatf("%s_hold%0d_ov", nm, h), int'(out_valid), 1);
      chk($sformatf("%s_hold%0d_pt", nm, h), int'(plaintext), exp_pt);
      chk($sformatf("%s_hold%0d_rdy", nm, h), int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_ov_after_hs"}, int'(out_valid), 0);
    chk({nm, "_rdy_after_hs"}, int'(in_ready), 1);
  endtask

  task automatic run_frame(input string nm, input int exp_pt, input int hold);
    out_ready = (hold == 0);
    send_rows(nm, 0, DIM);
    finish_frame(nm, exp_pt, hold);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    ciphertext = '0;
    secretkey  = '0;

    tbl[0] = '{c0: 0, s0: 0, c1: 80,   exp_pt: 5};
    tbl[1] = '{c0: 0, s0: 0, c1: 87,   exp_pt: 5};
    tbl[2] = '{c0: 0, s0: 0, c1: 88,   exp_pt: 6};
    tbl[3] = '{c0: 3, s0: 2, c1: 86,   exp_pt: 5};
    tbl[4] = '{c0: 0, s0: 0, c1: 1020, exp_pt: 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_plaintext", int'(plaintext), 0);
    rst = 1'b0;

    // Directed table; row-1 key is nonzero to show it is ignored.
    for (int i = 0; i < 5; i++) begin
      clear_frame();
      c_arr[0] = tbl[i].c0;
      s_arr[0] = tbl[i].s0;
      c_arr[1] = tbl[i].c1;
      s_arr[1] = 7;
      run_frame($sformatf("vec%0d", i), tbl[i].exp_pt, 0);
    end

    // Back-pressure with in_valid held high; next frame must start right after.
    clear_frame();
    c_arr[1] = 80;
    run_frame("hold", 5, 5);
    clear_frame();
    c_arr[1] = 88;
    run_frame("after_hold", 6, 0);

    // Reset mid-frame, with a word offered on the reset edge.
    clear_frame();
    c_arr[1] = 200;
    out_ready = 1'b1;
    send_rows("midrst", 0, 5);
    @(negedge clk);
    in_valid   = 1'b1;
    ciphertext = CW'(300);
    rst        = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("midrst_ov", int'(out_valid), 0);
    chk("midrst_rdy", int'(in_ready), 1);
    chk("midrst_pt", int'(plaintext), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_quiet%0d", k), int'(out_valid), 0);
    end
    clear_frame();
    c_arr[1] = 80;
    run_frame("post_midrst", 5, 0);

    // Reset while a result is pending in OUT.
    clear_frame();
    c_arr[1] = 400;
    out_ready = 1'b0;
    send_rows("outrst", 0, DIM);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("outrst_ov_before", int'(out_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("outrst_ov", int'(out_valid), 0);
    chk("outrst_pt", int'(plaintext), 0);
    chk("outrst_rdy", int'(in_ready), 1);
    out_ready = 1'b1;

    // Randomized frames against the reference model.
    for (int f = 0; f < 30; f++) begin
      for (int r = 0; r <= DIM; r++) begin
        c_arr[r] = int'($urandom_range(0, Q - 1));
        s_arr[r] = int'($urandom_range(0, Q - 1));
      end
      run_frame($sformatf("rnd%0d", f), model_pt(), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decrypt.md
DECRYPT -- requirements
Module: decrypt

Interface
REQ-001 SHALL have parameter PLAINTEXT_MODULUS, default 64: message modulus p.
REQ-002 SHALL have parameter PLAINTEXT_WIDTH, default 6: log2(p).
REQ-003 SHALL have parameter CIPHERTEXT_MODULUS, default 1024: ciphertext modulus q, which SHALL equal 2^CIPHERTEXT_WIDTH.
REQ-004 SHALL have parameter CIPHERTEXT_WIDTH, default 10: log2(q).
REQ-005 SHALL have parameter DIMENSION, default 10: a frame is DIMENSION+1 words, rows 0..DIMENSION.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1 bit: a ciphertext word is presented.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a word.
REQ-010 SHALL have port ciphertext, input, CIPHERTEXT_WIDTH bits: the current row word from the encrypt stage.
REQ-011 SHALL have port secretkey, input, CIPHERTEXT_WIDTH bits: the key coefficient for the current row; ignored on MSG_ROW.
REQ-012 SHALL have port out_valid, output, 1 bit: plaintext is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts plaintext.
REQ-014 SHALL have port plaintext, output, PLAINTEXT_WIDTH bits: the decrypted message.

Function
REQ-015 A word SHALL transfer on any edge where in_valid and in_ready are both 1; rows SHALL be counted implicitly 0..DIMENSION by an internal row counter.
REQ-016 FSM states SHALL be ACCUM, ROUND and OUT, with reset entering ACCUM with row=0 and acc=0.
REQ-017 In ACCUM, in_ready SHALL be 1; in ROUND and OUT, in_ready SHALL be 0.
REQ-018 On transfer of the word on MSG_ROW (row 1), acc SHALL become acc + ciphertext mod q.
REQ-019 On transfer of any other row, acc SHALL become acc - (ciphertext*secretkey mod q) mod q.
REQ-020 All arithmetic SHALL truncate to CIPHERTEXT_WIDTH bits; no saturation SHALL occur.
REQ-021 Transfer of row DIMENSION SHALL move the FSM to ROUND and reset row to 0.
REQ-022 ROUND SHALL last exactly 1 cycle and SHALL register plaintext = ((acc + q/(2p)) mod q) >> (CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH); the FSM SHALL then enter OUT.
REQ-023 out_valid SHALL be 1 exactly in OUT, starting 2 edges after the last word transfer.
REQ-024 While out_ready is 0, plaintext and out_valid SHALL hold stable.
REQ-025 On out_valid&&out_ready, the FSM SHALL return to ACCUM with acc=0 on the next edge, so the next frame's first word can transfer one cycle later.
REQ-026 in_valid asserted during ROUND or OUT SHALL be ignored, with no transfer taking place.

Reset
REQ-027 rst SHALL dominate every other input on the same edge.
REQ-028 Reset values SHALL be: in_ready=1 after the reset edge, out_valid=0, plaintext=0, acc=0, row=0, state=ACCUM.
REQ-029 Reset mid-frame or while in OUT SHALL discard the partial or pending result without emitting it.

Configuration
REQ-030 With macro DECRYPT_NOISE_OUT_EN defined, an extra output port noise, CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH bits, SHALL be present and SHALL carry the low bits of acc registered in ROUND; it SHALL be valid and held with plaintext and reset to 0.
REQ-031 With DECRYPT_NOISE_OUT_EN undefined, the noise port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 Shared package lwe_pkg SHALL hold the default moduli and widths, MSG_ROW=1, the FSM state enum, and the rounding-offset function q/(2p).
REQ-033 Sub-module modq_mac SHALL be combinational: acc_next from (acc, ciphertext, secretkey, is_msg_row), mod q.

Verification (p=64, q=1024, DIMENSION=10)
REQ-034 The bench SHALL drive all non-message words at 0 and the row-1 word at 80 -> plaintext=5, out_valid 2 edges after the row-10 transfer.
REQ-035 The bench SHALL drive the row-1 word at 87, then at 88 (others 0) -> plaintext=5, then 6 (rounding boundary).
REQ-036 The bench SHALL drive row 0 at c=3, s=2, row 1 at 86, others 0 -> acc=80, plaintext=5.
REQ-037 The bench SHALL drive the row-1 word at 1020, others 0 -> wrap gives (1028 mod 1024)>>4 = 0 -> plaintext=0.
REQ-038 The bench SHALL hold out_ready=0 for 5 cycles with in_valid=1 -> plaintext and out_valid held, in_ready=0, no word consumed; after release, the next frame starts 1 cycle later.
REQ-039 The bench SHALL assert rst after row 5 of a frame -> no out_valid; a following clean frame with the row-1 word at 80 -> plaintext=5.
